// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: ALU commit, load request/format, load-use hazard status
module wb_stage #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy_in,
  input  logic           ex_valid,
  output logic           ex_ready,
  input  logic           ex_wb_en,
  input  logic           ex_is_load,
  input  logic [2:0]     ex_funct3,
  input  logic [4:0]     ex_rd,
  input  logic [LEN-1:0] ex_result,
  output logic           mem_req,
  output logic [LEN-1:0] mem_addr,
  input  logic           mem_done,
  input  logic [LEN-1:0] mem_rdata,
  output logic           wb_flag,
  output logic [4:0]     wb_rd,
  output logic [LEN-1:0] wb_data,
  output logic           busy,
  output logic [4:0]     pending_rd,
  output logic           ld_err
);

  typedef enum logic {S_IDLE, S_MEM_WAIT} state_t;

  state_t         state_q, state_d;
  logic [LEN-1:0] mem_addr_q, mem_addr_d;
  logic           wb_flag_q, wb_flag_d;
  logic [4:0]     wb_rd_q, wb_rd_d;
  logic [LEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]     pending_rd_q, pending_rd_d;
  logic           ld_err_q, ld_err_d;
  logic [4:0]     rd_q, rd_d;
  logic           wb_en_q, wb_en_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [1:0]     off_q, off_d;

  logic           accept;
  logic           ld_ok;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic [LEN-1:0] ld_data;

  assign ex_ready   = (state_q == S_IDLE);
  assign accept     = ex_valid & ex_ready;
  assign mem_req    = (state_q == S_MEM_WAIT);
  assign busy       = (state_q == S_MEM_WAIT);
  assign mem_addr   = mem_addr_q;
  assign wb_flag    = wb_flag_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign pending_rd = pending_rd_q;
  assign ld_err     = ld_err_q;

  // Illegal funct3 and misaligned addresses share the same error response.
  always_comb begin
    ld_ok = 1'b0;
    case (ex_funct3)
      3'b000, 3'b100: ld_ok = 1'b1;
      3'b001, 3'b101: ld_ok = ~ex_result[0];
      3'b010:         ld_ok = (ex_result[1:0] == 2'b00);
      default:        ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{(LEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {{(LEN-8){1'b0}}, byte_sel};
      3'b001:  ld_data = {{(LEN-16){half_sel[15]}}, half_sel};
      3'b101:  ld_data = {{(LEN-16){1'b0}}, half_sel};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    wb_flag_d    = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    pending_rd_d = pending_rd_q;
    ld_err_d     = 1'b0;
    rd_d         = rd_q;
    wb_en_d      = wb_en_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!ex_is_load) begin
            wb_flag_d = ex_wb_en & (ex_rd != 5'd0);
            wb_rd_d   = ex_rd;
            wb_data_d = ex_result;
          end else if (!ld_ok) begin
            ld_err_d = 1'b1;
          end else begin
            state_d      = S_MEM_WAIT;
            mem_addr_d   = {ex_result[LEN-1:2], 2'b00};
            pending_rd_d = ex_wb_en ? ex_rd : 5'd0;
            rd_d         = ex_rd;
            wb_en_d      = ex_wb_en;
            funct3_d     = ex_funct3;
            off_d        = ex_result[1:0];
          end
        end
      end
      S_MEM_WAIT: begin
        if (mem_done) begin
          state_d      = S_IDLE;
          pending_rd_d = 5'd0;
          wb_flag_d    = wb_en_q & (rd_q != 5'd0);
          wb_rd_d      = rd_q;
          wb_data_d    = ld_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      wb_flag_q    <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      pending_rd_q <= 5'd0;
      ld_err_q     <= 1'b0;
      rd_q         <= 5'd0;
      wb_en_q      <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      wb_flag_q    <= wb_flag_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      pending_rd_q <= pending_rd_d;
      ld_err_q     <= ld_err_d;
      rd_q         <= rd_d;
      wb_en_q      <= wb_en_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy_in = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_wb_en = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic [31:0] ex_result = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_flag;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [4:0]  pending_rd;
  logic        ld_err;

  int n_tests = 0;
  int n_fail  = 0;

  wb_stage #(.LEN(32)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wb_en(ex_wb_en),
    .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_result(ex_result), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .wb_flag(wb_flag),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy),
    .pending_rd(pending_rd), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res);
    ex_valid   = 1'b1;
    ex_is_load = ld;
    ex_funct3  = f3;
    ex_rd      = rd;
    ex_wb_en   = 1'b1;
    ex_result  = res;
  endtask

  task automatic idle_ex();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
  endtask

  task automatic load_run(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input int waits, input logic [31:0] exp);
    int req_cycles;
    issue(1'b1, f3, rd, addr);
    step();
    idle_ex();
    req_cycles = 0;
    check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, "_pend"}, {27'd0, pending_rd}, {27'd0, rd});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_rdy0"}, {31'd0, ex_ready}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      if (mem_req) req_cycles++;
      step();
    end
    if (mem_req) req_cycles++;
    mem_done  = 1'b1;
    mem_rdata = rdata;
    step();
    mem_done = 1'b0;
    check({tag, "_reqcyc"}, req_cycles, waits + 1);
    check({tag, "_flag"}, {31'd0, wb_flag}, 32'd1);
    check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_req0"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_rdy1"}, {31'd0, ex_ready}, 32'd1);
    check({tag, "_pend0"}, {27'd0, pending_rd}, 32'd0);
  endtask

  task automatic err_run(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    issue(1'b1, f3, 5'd6, addr);
    step();
    idle_ex();
    check({tag, "_err"}, {31'd0, ld_err}, 32'd1);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_flag"}, {31'd0, wb_flag}, 32'd0);
    check({tag, "_rdy"}, {31'd0, ex_ready}, 32'd1);
    step();
    check({tag, "_err_off"}, {31'd0, ld_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] alu_res [3];
    alu_res[0] = 32'h11; alu_res[1] = 32'h22; alu_res[2] = 32'h33;

    #12;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_flag", {31'd0, wb_flag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, ld_err}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_pend", {27'd0, pending_rd}, 32'd0);
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    rst = 1'b1;
    step();

    // ALU stream, one commit per cycle
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 3'd0, 5'(i + 1), alu_res[i]);
      step();
      check("alu_flag", {31'd0, wb_flag}, 32'd1);
      check("alu_rd", {27'd0, wb_rd}, 32'(i + 1));
      check("alu_data", wb_data, alu_res[i]);
    end
    idle_ex();
    step();
    check("alu_flag_off", {31'd0, wb_flag}, 32'd0);

    load_run("lb", 3'b000, 5'd5, 32'h0000_1003, 32'h80FF_7F01, 3, 32'hFFFF_FF80);
    load_run("lbu", 3'b100, 5'd4, 32'h0000_1001, 32'h80FF_7F01, 1, 32'h0000_007F);
    load_run("lhu", 3'b101, 5'd8, 32'h0000_2002, 32'h8001_0000, 0, 32'h0000_8001);
    load_run("lh", 3'b001, 5'd9, 32'h0000_2002, 32'h8001_0000, 2, 32'hFFFF_8001);
    load_run("lw", 3'b010, 5'd10, 32'h0000_2004, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    step();
    check("ld_flag_off", {31'd0, wb_flag}, 32'd0);

    err_run("lw_mis", 3'b010, 32'h0000_3001);
    err_run("f3_011", 3'b011, 32'h0000_3000);
    err_run("lh_mis", 3'b001, 32'h0000_3003);

    issue(1'b0, 3'd0, 5'd0, 32'h55);
    step();
    idle_ex();
    check("rd0_flag", {31'd0, wb_flag}, 32'd0);
    check("rd0_ready", {31'd0, ex_ready}, 32'd1);

    // Reset in the middle of a load wait
    issue(1'b1, 3'b010, 5'd12, 32'h0000_5000);
    step();
    idle_ex();
    step();
    check("rstw_req_pre", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstw_req", {31'd0, mem_req}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_pend", {27'd0, pending_rd}, 32'd0);
    step();
    rst = 1'b1;
    mem_done  = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_done = 1'b0;
    check("rstw_stray_flag", {31'd0, wb_flag}, 32'd0);
    check("rstw_stray_ready", {31'd0, ex_ready}, 32'd1);
    issue(1'b0, 3'd0, 5'd7, 32'h77);
    step();
    idle_ex();
    check("rstw_alu_flag", {31'd0, wb_flag}, 32'd1);
    check("rstw_alu_data", wb_data, 32'h77);

    // rdy_in low freezes state while mem_done pulses
    issue(1'b1, 3'b010, 5'd9, 32'h0000_4000);
    step();
    idle_ex();
    rdy_in    = 1'b0;
    mem_done  = 1'b1;
    mem_rdata = 32'hAAAA_AAAA;
    step();
    step();
    check("frz_req", {31'd0, mem_req}, 32'd1);
    check("frz_busy", {31'd0, busy}, 32'd1);
    check("frz_pend", {27'd0, pending_rd}, 32'd9);
    check("frz_flag", {31'd0, wb_flag}, 32'd0);
    rdy_in   = 1'b1;
    mem_done = 1'b0;
    step();
    check("frz_req_after", {31'd0, mem_req}, 32'd1);
    mem_done  = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_done = 1'b0;
    check("frz_done_flag", {31'd0, wb_flag}, 32'd1);
    check("frz_done_rd", {27'd0, wb_rd}, 32'd9);
    check("frz_done_data", wb_data, 32'h1234_5678);
    check("frz_done_req", {31'd0, mem_req}, 32'd0);
    step();
    check("frz_flag_off", {31'd0, wb_flag}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
